// File: rtl/blinky_pwm_if.sv
// -----------------------------------------------------------------------------
// blinky_pwm_if
// Write port carrying per-channel {mode, duty} updates into blinky_pwm.
//
// Signals:
//   wr_en    1                    write strobe, one write per asserted cycle
//   wr_ch    $clog2(CHANNELS)+1   target channel (values >= CHANNELS ignored)
//   wr_mode  3                    channel mode
//   wr_duty  PWM_BITS             channel duty
//
// Modports:
//   master  drives the write port (board logic / testbench)
//   slave   receives the write port (blinky_pwm)
// -----------------------------------------------------------------------------
interface blinky_pwm_if #(
    parameter int CHANNELS = 8,
    parameter int PWM_BITS = 8
);
    localparam int CH_W = $clog2(CHANNELS) + 1;

    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [2:0]          wr_mode;
    logic [PWM_BITS-1:0] wr_duty;

    modport master (
        output wr_en,
        output wr_ch,
        output wr_mode,
        output wr_duty
    );

    modport slave (
        input wr_en,
        input wr_ch,
        input wr_mode,
        input wr_duty
    );
endinterface

// File: rtl/blinky_pwm.sv
// -----------------------------------------------------------------------------
// blinky_pwm
// Multi-channel PWM / blink / breathe driver for PMOD pins and the on-board
// active-low LED. A prescaler produces PWM ticks, a PWM counter defines the
// period, and each channel compares the counter against its active duty.
// Channel settings are double-buffered: writes land in a shadow copy that is
// transferred to the active copy on the period boundary edge.
//
// Optional feature: define BLINKY_BREATHE_EN to add the shared breathe ramp
// (mode 4). Without it, mode 4 drives 0.
//
// Ports:
//   clk48         in   1         system clock
//   rst           in   1         asynchronous active-high reset
//   wr            slave          write port {wr_en, wr_ch, wr_mode, wr_duty}
//   pwm_out       out  CHANNELS  registered channel outputs
//   period_start  out  1         one-cycle pulse on the first output cycle
//                                of each period
//   led           out  1         active-low LED, ~pwm_out[0]
// -----------------------------------------------------------------------------
module blinky_pwm #(
    parameter int CHANNELS      = 8,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 188,
    parameter int BLINK_PERIODS = 64
) (
    input  logic                clk48,
    input  logic                rst,
    blinky_pwm_if.slave         wr,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic                led
);
    localparam int CH_W  = $clog2(CHANNELS) + 1;
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

    localparam logic [2:0] MODE_OFF     = 3'd0;
    localparam logic [2:0] MODE_ON      = 3'd1;
    localparam logic [2:0] MODE_PWM     = 3'd2;
    localparam logic [2:0] MODE_BLINK   = 3'd3;
    localparam logic [2:0] MODE_BREATHE = 3'd4;

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_ph;
    logic                tick;
    logic                boundary;
    logic                bnd_p0;

    logic [2:0]          shadow_mode [CHANNELS];
    logic [PWM_BITS-1:0] shadow_duty [CHANNELS];
    logic [2:0]          active_mode [CHANNELS];
    logic [PWM_BITS-1:0] active_duty [CHANNELS];

    logic [CHANNELS-1:0] pwm_nxt;

    function automatic logic cmp(input logic [PWM_BITS-1:0] cnt,
                                 input logic [PWM_BITS-1:0] d);
        return cnt < d;
    endfunction

    assign tick     = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign boundary = tick && (pwm_cnt == DUTY_MAX);

    // Stage p0: prescaler, PWM counter and blink phase
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            if (boundary) begin
                if (blink_cnt == BLK_W'(BLINK_PERIODS - 1)) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
            end
        end
    end

    // Active copy takes the shadow value present before this edge, so a write
    // landing on the boundary edge only reaches the shadow and goes live one
    // period later.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                shadow_mode[ch] <= MODE_OFF;
                shadow_duty[ch] <= '0;
                active_mode[ch] <= MODE_OFF;
                active_duty[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (boundary) begin
                    active_mode[ch] <= shadow_mode[ch];
                    active_duty[ch] <= shadow_duty[ch];
                end
                // Full-width channel compare: out-of-range channels never alias
                if (wr.wr_en && (wr.wr_ch == CH_W'(ch))) begin
                    shadow_mode[ch] <= wr.wr_mode;
                    shadow_duty[ch] <= wr.wr_duty;
                end
            end
        end
    end

`ifdef BLINKY_BREATHE_EN
    logic [PWM_BITS-1:0] ramp;
    logic                ramp_down;

    function automatic logic [PWM_BITS-1:0] sat_min(input logic [PWM_BITS-1:0] a,
                                                    input logic [PWM_BITS-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Triangle ramp; endpoints are visited once before reversing
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            ramp      <= '0;
            ramp_down <= 1'b0;
        end else if (boundary) begin
            if (!ramp_down) begin
                if (ramp == DUTY_MAX) begin
                    ramp      <= ramp - PWM_BITS'(1);
                    ramp_down <= 1'b1;
                end else begin
                    ramp <= ramp + PWM_BITS'(1);
                end
            end else begin
                if (ramp == '0) begin
                    ramp      <= ramp + PWM_BITS'(1);
                    ramp_down <= 1'b0;
                end else begin
                    ramp <= ramp - PWM_BITS'(1);
                end
            end
        end
    end
`endif

    always_comb begin
        pwm_nxt = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            case (active_mode[ch])
                MODE_ON:      pwm_nxt[ch] = 1'b1;
                MODE_PWM:     pwm_nxt[ch] = cmp(pwm_cnt, active_duty[ch]);
                MODE_BLINK:   pwm_nxt[ch] = blink_ph & cmp(pwm_cnt, active_duty[ch]);
`ifdef BLINKY_BREATHE_EN
                MODE_BREATHE: pwm_nxt[ch] = cmp(pwm_cnt, sat_min(ramp, active_duty[ch]));
`else
                MODE_BREATHE: pwm_nxt[ch] = 1'b0;
`endif
                default:      pwm_nxt[ch] = 1'b0;
            endcase
        end
    end

    // Stage p1: registered outputs; period_start is delayed one cycle so it
    // lines up with the first output computed from the newly loaded settings.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            bnd_p0       <= 1'b0;
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            bnd_p0       <= boundary;
            pwm_out      <= pwm_nxt;
            period_start <= bnd_p0;
        end
    end

    assign led = ~pwm_out[0];

endmodule
